// File: rtl/calc_seq_alu.sv
// Sequential arithmetic core: single-cycle add/sub/logic, iterative shift-add multiply
// and restoring divide/modulo, with start/busy/done handshake and design-wide ena stall.
module calc_seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 err
);

  localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_MOD = 3'b111
  } op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_d, op_in;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d, err_q, err_d;

  logic [WIDTH:0]       msum, rs, sum_w, dif_w;
  logic [WIDTH-1:0]     mul_hi, mul_lo, div_r, div_q;
  logic                 dneg, iter, div0, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  // Step logic. Mul keeps {partial hi, multiplier} in hi/lo and shifts right;
  // div keeps {remainder, dividend->quotient} in hi/lo and shifts left.
  always_comb begin
    op_in  = op_e'(op);
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], lo_q[WIDTH-1:1]};
    rs     = {hi_q, lo_q[WIDTH-1]};
    dneg   = (rs < {1'b0, b_q});
    div_r  = dneg ? rs[WIDTH-1:0] : (rs[WIDTH-1:0] - b_q);
    div_q  = {lo_q[WIDTH-2:0], ~dneg};
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    dif_w  = {1'b0, a_q} - {1'b0, b_q};
    iter   = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD);
    div0   = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);
    finish = (state_q == RUN) && (!iter || div0 || (cnt_q == '0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (finish) state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    if ((state_q == IDLE) && start) begin
      op_d  = op_in;
      a_d   = a;
      b_d   = b;
      hi_d  = '0;
      lo_d  = (op_in == OP_MUL) ? b : a;
      cnt_d = ((op_in == OP_MUL) || (op_in == OP_DIV) || (op_in == OP_MOD)) ? CNT_LAST : '0;
    end else if (state_q == RUN) begin
      if (iter && !div0) begin
        if (op_q == OP_MUL) begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end else begin
          hi_d = div_r;
          lo_d = div_q;
        end
        if (!finish) cnt_d = cnt_q - CW'(1);
      end
      if (finish) begin
        done_d  = 1'b1;
        carry_d = 1'b0;
        err_d   = 1'b0;
        case (op_q)
          OP_ADD: begin
            carry_d  = sum_w[WIDTH];
            result_d = {{WIDTH{1'b0}}, (SAT && sum_w[WIDTH]) ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0]};
          end
          OP_SUB: begin
            carry_d  = dif_w[WIDTH];
            result_d = {{WIDTH{1'b0}}, (SAT && dif_w[WIDTH]) ? {WIDTH{1'b0}} : dif_w[WIDTH-1:0]};
          end
          OP_AND: result_d = {{WIDTH{1'b0}}, a_q & b_q};
          OP_OR:  result_d = {{WIDTH{1'b0}}, a_q | b_q};
          OP_XOR: result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
          OP_MUL: result_d = {mul_hi, mul_lo};
          OP_DIV: begin
            err_d    = div0;
            result_d = div0 ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {div_r, div_q};
          end
          OP_MOD: begin
            err_d    = div0;
            result_d = div0 ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, div_r};
          end
        endcase
      end
    end
  end

  always_comb begin
    busy   = (state_q == RUN);
    done   = done_q;
    result = result_q;
    carry  = carry_q;
    err    = err_q;
    zero   = (result_q == '0);
  end

endmodule

// File: doc/calc_seq_alu.md
# calc_seq_alu

Parametrised sequential arithmetic core for the calculator tile; it generalises the fixed 8-bit calculator datapath to a WIDTH-bit operand path. It adds iterative multiply, divide and modulo, optional saturating add/sub, and a start/busy/done handshake. It sits between the operand/opcode capture logic and the output multiplexer inside the `tt_um_randyzhu_calc` top level.

## Interface
- `WIDTH`, default 8: operand width, legal 4..16.
- `SAT`, default 0: 1 = add/sub saturate; 0 = add/sub wrap.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: when 0, every register holds its value (design-wide stall).
- `start` in 1: request; sampled only in IDLE with `ena`=1.
- `op` in 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 mod.
- `a` in WIDTH: operand A, unsigned.
- `b` in WIDTH: operand B, unsigned.
- `busy` out 1: operation in progress.
- `done` out 1: one-enabled-cycle completion pulse.
- `result` out 2*WIDTH: registered result.
- `carry` out 1: add carry-out / sub borrow, else 0.
- `zero` out 1: `result`==0.
- `err` out 1: divide/modulo by zero.

## Operation
- States: IDLE, RUN.
- IDLE + `start`=1 + `ena`=1:
  - latch `a`, `b`, `op`; go to RUN; `busy`=1.
  - load iteration counter with WIDTH-1 for mul/div/mod, 0 otherwise.
- RUN, single-step ops (add, sub, and, or, xor, and div/mod with `b`=0):
  - compute in one cycle; write result and flags; `done`=1; `busy`=0; return to IDLE.
- RUN, mul: shift-add, one multiplier bit per cycle, LSB first; 2*WIDTH-bit product.
- RUN, div/mod: restoring division, one quotient bit per cycle, MSB first.
- Mul/div/mod finish when the counter reaches 0; then write result and flags, assert `done`, drop `busy`, return to IDLE.
- Result packing:
  - add/sub/logic: `result`={WIDTH zeros, low WIDTH bits}.
  - mul: full product.
  - div: {remainder, quotient}.
  - mod: {WIDTH zeros, remainder}.
- add: `carry`=carry-out; SAT=1 and carry → low half all ones.
- sub: low = a−b mod 2^WIDTH; `carry`=1 iff a<b; SAT=1 and borrow → low half 0.
- Divide by zero:
  - div: `result`={WIDTH zeros, all ones}; mod: `result`={WIDTH zeros, a}.
  - `err`=1 in both cases; no iteration.
- `err`=0 and `carry`=0 for every other case where not defined above.
- `result`, `carry`, `zero`, `err` change only at completion and hold until the next completion.
- `start` while busy: ignored, not queued.
- Operand/op changes after acceptance do not affect the running operation.

## Timing
- Reset values (async, immediate): state IDLE, `busy`=0, `done`=0, `result`=0, `carry`=0, `err`=0, `zero`=1 (follows `result`).
- Accepting edge E0 → `busy`=1 after E0.
- Latency to `done`:
  - single-step ops: `done`=1 and `busy`=0 after E1.
  - mul/div/mod: after E_WIDTH, so `busy` is high for WIDTH cycles.
- `done` is high exactly one enabled cycle. A `start` in the `done` cycle is accepted, since the state is already IDLE (back-to-back issue).
- `ena`=0 cycles freeze state, counter, `done` and `busy`; latency stretches by exactly the number of stalled cycles.
- Reset asserted mid-operation aborts immediately; no `done` is produced.

## Test plan
- WIDTH=8, SAT=0, add 200+100 → `result`=0x002C, `carry`=1, `done` one cycle after acceptance.
- WIDTH=8, SAT=1:
  - add 200+100 → `result`=0x00FF, `carry`=1.
  - sub 5−9 → `result`=0x0000, `carry`=1.
- WIDTH=8, mul 255×255 → `busy` high 8 cycles, then `result`=0xFE01, `zero`=0.
- WIDTH=8:
  - div 200/7 → `result`=0x041C after 8 cycles.
  - mod 200/7 → 0x0004.
  - div 9/0 → `result`=0x00FF, `err`=1, latency 1.
- WIDTH=16, mul 0xFFFF×2 → `result`=0x0001FFFE after 16 busy cycles.
  - `start` pulsed mid-run is ignored; the next `start` in the `done` cycle is accepted.
- WIDTH=8, mul 3×4 with `ena`=0 for 3 cycles mid-run → `done` 11 cycles after acceptance, `result`=0x000C.
  - `rst_n` low mid-run → `busy`=0, `result`=0 immediately, no `done`.
